mux_sel_pipe: RTL

- Parametrised N-to-1 datapath selector with a registered output stage and a valid/ready handshake.
- Successor to the fixed-arity combinational 2/4/5/6/7-to-1 32-bit selectors used in the datapath.
- Inserts a pipeline cut with a 2-entry skid buffer so operand and writeback select paths can be retimed without losing beats under backpressure.
- Also flags out-of-range selects.

---
 rtl/mux_sel_pipe.sv | 113 +++++++++++
 1 files changed

// File: rtl/mux_sel_pipe.sv
// N-to-1 word selector with a registered output and a 2-entry skid buffer on a valid/ready
// handshake. Accepted beats with an out-of-range select carry input 0 and raise a sticky flag.
module mux_sel_pipe #(
  parameter int unsigned W  = 32,
  parameter int unsigned N  = 7,
  parameter int unsigned SW = $clog2(N)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic [N*W-1:0] in_data_i,
  input  logic [SW-1:0]  sel_i,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  output logic [W-1:0]   out_data_o,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic           sel_err_o,
  input  logic           err_clr_i
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   main_q, main_d;
  logic [W-1:0]   skid_q, skid_d;
  logic           out_valid_q;
  logic           in_ready_q;
  logic           sel_err_q, sel_err_d;

  logic [W-1:0]   muxed;
  logic           sel_oor;
  logic           in_fire;
  logic           out_fire;

  // Out-of-range selects fall through to input 0.
  always_comb begin
    muxed = in_data_i[0 +: W];
    for (int unsigned k = 1; k < N; k++) begin
      if (sel_i == SW'(k)) muxed = in_data_i[k*W +: W];
    end
  end

  assign sel_oor  = ({1'b0, sel_i} >= (SW+1)'(N));
  assign in_fire  = in_valid_i & in_ready_q;
  assign out_fire = out_valid_q & out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (in_fire) begin
          state_d = StOne;
          main_d  = muxed;
        end
      end
      StOne: begin
        if (in_fire && out_fire) begin
          main_d = muxed;
        end else if (in_fire) begin
          state_d = StFull;
          skid_d  = muxed;
        end else if (out_fire) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (out_fire) begin
          state_d = StOne;
          main_d  = skid_q;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // A set in the same cycle as a clear takes priority.
  always_comb begin
    sel_err_d = sel_err_q;
    if (in_fire && sel_oor) begin
      sel_err_d = 1'b1;
    end else if (err_clr_i) begin
      sel_err_d = 1'b0;
    end
  end

  // Ready and valid are registered from the next state, so ready never sees same-cycle
  // out_ready_i and stays low throughout reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StEmpty;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= (state_d != StEmpty);
      in_ready_q  <= (state_d != StFull);
      sel_err_q   <= sel_err_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = main_q;
  assign sel_err_o   = sel_err_q;

endmodule
